// File: rtl/lock_pkg.sv
// Shared constants for the lock controller display path: digit codes,
// active-high 7-segment glyphs {g,f,e,d,c,b,a} and a polarity helper.
package lock_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [3:0] DIGIT_E     = 4'hE;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1101111;
  localparam logic [6:0] GLYPH_E     = 7'b1111001;
  localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  // Convert an active-high {dp, seg} byte to the pin level of the display.
  function automatic logic [7:0] apply_polarity(input logic [7:0] v, input logic active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// 4-bit digit code to active-high 7-segment glyph {g,f,e,d,c,b,a}.
module seg7_decode
  import lock_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph_c
);

  always_comb begin
    glyph_c = GLYPH_BLANK;
    case (code)
      4'h0:                    glyph_c = GLYPH_0;
      4'h1:                    glyph_c = GLYPH_1;
      4'h2:                    glyph_c = GLYPH_2;
      4'h3:                    glyph_c = GLYPH_3;
      4'h4:                    glyph_c = GLYPH_4;
      4'h5:                    glyph_c = GLYPH_5;
      4'h6:                    glyph_c = GLYPH_6;
      4'h7:                    glyph_c = GLYPH_7;
      4'h8:                    glyph_c = GLYPH_8;
      4'h9:                    glyph_c = GLYPH_9;
      4'hA, 4'hB, 4'hC, 4'hD:  glyph_c = GLYPH_DASH;
      DIGIT_E:                 glyph_c = GLYPH_E;
      default:                 glyph_c = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 6-digit 7-segment driver with per-frame snapshot,
// ghost-blanking gap between digits and whole-display blink.
module seg7_scan_driver
  import lock_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          ACTIVE_LOW   = 1'b1
)(
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  en,
  input  logic [3:0]            d1,
  input  logic [3:0]            d2,
  input  logic [3:0]            d3,
  input  logic [3:0]            d4,
  input  logic [3:0]            d5,
  input  logic [3:0]            d6,
  input  logic [NUM_DIGITS-1:0] dp,
  input  logic                  blink_en,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick
);

  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned IDX_W  = 3;

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [FCNT_W-1:0]     FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            OFF_SEG   = apply_polarity(8'h00, ACTIVE_LOW);
  localparam logic [NUM_DIGITS-1:0] OFF_AN    = ACTIVE_LOW ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [FCNT_W-1:0]     fcnt;
  logic                  phase_on;
  logic [3:0]            snap [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_snap;

  logic                  slot_wrap_c;
  logic                  frame_wrap_c;
  logic                  blank_done_c;
  logic                  lit_c;
  logic [3:0]            cur_code_c;
  logic                  cur_dp_c;
  logic [6:0]            glyph_c;
  logic [NUM_DIGITS-1:0] an_on_c;
  logic [7:0]            seg_pins_c;

  seg7_decode u_decode (
    .code    (cur_code_c),
    .glyph_c (glyph_c)
  );

  // Scan timing and the digit/dp currently addressed by idx.
  always_comb begin
    slot_wrap_c  = en && (cnt == CNT_LAST);
    frame_wrap_c = slot_wrap_c && (idx == IDX_LAST);
    blank_done_c = (BLANK_CYC == 0) || (cnt >= BLANK_END);
    lit_c        = en && blank_done_c && phase_on;
    cur_code_c   = DIGIT_BLANK;
    cur_dp_c     = 1'b0;
    case (idx)
      3'd0: begin cur_code_c = snap[0]; cur_dp_c = dp_snap[0]; end
      3'd1: begin cur_code_c = snap[1]; cur_dp_c = dp_snap[1]; end
      3'd2: begin cur_code_c = snap[2]; cur_dp_c = dp_snap[2]; end
      3'd3: begin cur_code_c = snap[3]; cur_dp_c = dp_snap[3]; end
      3'd4: begin cur_code_c = snap[4]; cur_dp_c = dp_snap[4]; end
      3'd5: begin cur_code_c = snap[5]; cur_dp_c = dp_snap[5]; end
      default: ;
    endcase
    an_on_c    = lit_c ? (AN_ONE << idx) : '0;
    seg_pins_c = apply_polarity({cur_dp_c, glyph_c}, ACTIVE_LOW);
  end

  // Slot counter, digit index and frame snapshot.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt     <= '0;
      idx     <= '0;
      dp_snap <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= DIGIT_BLANK;
    end else if (en) begin
      cnt <= slot_wrap_c ? '0 : cnt + CNT_W'(1);
      if (slot_wrap_c) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      if (frame_wrap_c) begin
        snap[0] <= d1;
        snap[1] <= d2;
        snap[2] <= d3;
        snap[3] <= d4;
        snap[4] <= d5;
        snap[5] <= d6;
        dp_snap <= dp;
      end
    end
  end

  // Blink phase: dropping blink_en restarts it so the next blink begins ON.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      fcnt     <= '0;
      phase_on <= 1'b1;
    end else if (!blink_en) begin
      fcnt     <= '0;
      phase_on <= 1'b1;
    end else if (frame_wrap_c) begin
      if (fcnt == FCNT_LAST) begin
        fcnt     <= '0;
        phase_on <= ~phase_on;
      end else begin
        fcnt <= fcnt + FCNT_W'(1);
      end
    end
  end

  // Registered pin outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      seg        <= OFF_SEG[6:0];
      seg_dp     <= OFF_SEG[7];
      an         <= OFF_AN;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_pins_c[6:0];
      seg_dp     <= seg_pins_c[7];
      an         <= ACTIVE_LOW ? ~an_on_c : an_on_c;
      frame_tick <= frame_wrap_c;
    end
  end

endmodule
